// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/fa_bit.sv
// Combinational one-bit full adder; the single arithmetic cell of the serial datapath.
module fa_bit (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB-first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting (a - b) mod 2^WIDTH.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sa_q, sb_q, res_q, sum_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q, cout_q;
   logic               fa_s, fa_co;
   logic               last_bit;
   logic [WIDTH-1:0]   sb_load;
   logic               carry_load;

   fa_bit u_fa_bit (
      .x  (sa_q[0]),
      .y  (sb_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   // Subtraction is a + ~b + 1: invert B and preset the carry.
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      sb_load    = sub ? ~b : b;
      carry_load = sub;
`else
      sb_load    = b;
      carry_load = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= sb_load;
                  carry_q <= carry_load;
                  cnt_q   <= '0;
               end
            end
            SHIFT: begin
               sa_q    <= sa_q >> 1;
               sb_q    <= sb_q >> 1;
               carry_q <= fa_co;
               res_q   <= {fa_s, res_q[WIDTH-1:1]};
               cnt_q   <= cnt_q + CNT_W'(1);
               // Publish only the completed result; partial sums stay internal.
               if (last_bit) begin
                  sum_q  <= {fa_s, res_q[WIDTH-1:1]};
                  cout_q <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
